// File: rtl/larpix_config_responder_pkg.sv
// Shared definitions for the LArPix 64-bit configuration packet protocol.
// Both the chip-side responder and the master-side bench import this package.
package larpix_pkt_pkg;

  localparam int PKT_W    = 64;
  localparam int TYPE_LSB = 0;
  localparam int CHIP_LSB = 2;
  localparam int ADDR_LSB = 10;
  localparam int DATA_LSB = 18;
  localparam int FIFO_LSB = 58;
  localparam int DS_BIT   = 62;
  localparam int PAR_BIT  = 63;

  localparam logic [7:0] GLOBAL_ID = 8'd255;

  typedef enum logic [1:0] {
    DATA      = 2'd0,
    TEST      = 2'd1,
    CFG_WRITE = 2'd2,
    CFG_READ  = 2'd3
  } pkt_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WRITE,
    ST_READ,
    ST_CAPTURE,
    ST_RESP,
    ST_FWD
  } state_e;

  // Odd parity: the XOR over all 64 bits, parity bit included, must be 1.
  function automatic logic parity_ok(input logic [PKT_W-1:0] pkt);
    return ^pkt;
  endfunction

  function automatic logic [PKT_W-1:0] add_parity(input logic [PKT_W-1:0] pkt);
    logic [PKT_W-1:0] p;
    p = pkt;
    p[PAR_BIT] = ~(^pkt[PAR_BIT-1:0]);
    return p;
  endfunction

  function automatic logic [PKT_W-1:0] build_reply(input logic [1:0] typ,
                                                   input logic [7:0] chip,
                                                   input logic [7:0] addr,
                                                   input logic [7:0] data,
                                                   input logic [3:0] fifo);
    logic [PKT_W-1:0] p;
    p = '0;
    p[TYPE_LSB +: 2] = typ;
    p[CHIP_LSB +: 8] = chip;
    p[ADDR_LSB +: 8] = addr;
    p[DATA_LSB +: 8] = data;
    p[FIFO_LSB +: 4] = fifo;
    p[DS_BIT]        = 1'b1;
    return add_parity(p);
  endfunction

endpackage

// File: rtl/larpix_config_responder_if.sv
// Packet-in, register-map and packet-out signals between the responder and its neighbours.
interface larpix_config_responder_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] pkt_in;
  logic             pkt_in_valid;
  logic             pkt_in_ready;
  logic [7:0]       regmap_addr;
  logic [7:0]       regmap_wdata;
  logic             regmap_we;
  logic             regmap_re;
  logic [7:0]       regmap_rdata;
  logic [3:0]       fifo_status;
  logic [WIDTH-1:0] pkt_out;
  logic             pkt_out_valid;
  logic             pkt_out_ready;

  modport slave (
    input  pkt_in, pkt_in_valid, regmap_rdata, fifo_status, pkt_out_ready,
    output pkt_in_ready, regmap_addr, regmap_wdata, regmap_we, regmap_re,
           pkt_out, pkt_out_valid
  );

  modport master (
    output pkt_in, pkt_in_valid, regmap_rdata, fifo_status, pkt_out_ready,
    input  pkt_in_ready, regmap_addr, regmap_wdata, regmap_we, regmap_re,
           pkt_out, pkt_out_valid
  );
endinterface

// File: rtl/larpix_config_responder.sv
// Chip-side configuration responder: parity/ID check, register write/read,
// reply generation and downstream forwarding of foreign or broadcast packets.
module larpix_config_responder #(
  parameter int          WIDTH     = 64,
  parameter int unsigned REGNUM    = 256,
  parameter logic [7:0]  GLOBAL_ID = 8'd255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                chip_id,
  larpix_config_responder_if.slave  bus,
  output logic [7:0]                parity_err_cnt,
  output logic                      busy
);
  import larpix_pkt_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pkt_q, pkt_d;
  logic [WIDTH-1:0] pkt_out_q, pkt_out_d;
  logic             out_vld_q, out_vld_d;
  logic             in_ready_q, in_ready_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       perr_q, perr_d;

  logic [1:0] req_type;
  logic [7:0] req_chip, req_addr, req_data;
  logic       is_bcast, is_local, in_range, handshake;

  assign req_type  = pkt_q[TYPE_LSB +: 2];
  assign req_chip  = pkt_q[CHIP_LSB +: 8];
  assign req_addr  = pkt_q[ADDR_LSB +: 8];
  assign req_data  = pkt_q[DATA_LSB +: 8];
  assign is_bcast  = (req_chip == GLOBAL_ID);
  assign is_local  = is_bcast || (req_chip == chip_id);
  assign in_range  = (32'(req_addr) < REGNUM);
  assign handshake = out_vld_q && bus.pkt_out_ready;

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    pkt_out_d = pkt_out_q;
    out_vld_d = out_vld_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    addr_d    = 8'd0;
    wdata_d   = 8'd0;
    perr_d    = perr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_ready_q && bus.pkt_in_valid) begin
          pkt_d   = bus.pkt_in;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!parity_ok(pkt_q)) begin
          if (perr_q != 8'hFF) perr_d = perr_q + 8'd1;
          state_d = ST_IDLE;
        end else if (!is_local) begin
          pkt_out_d = pkt_q;
          out_vld_d = 1'b1;
          state_d   = ST_FWD;
        end else begin
          case (req_type)
            CFG_WRITE: begin
              we_d    = in_range;
              addr_d  = req_addr;
              wdata_d = req_data;
              state_d = ST_WRITE;
            end
            CFG_READ: begin
              re_d    = in_range;
              addr_d  = req_addr;
              state_d = ST_READ;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: begin
        // fifo_status is sampled on the edge that enters RESP
        pkt_out_d = build_reply(req_type, chip_id, req_addr,
                                in_range ? req_data : 8'd0, bus.fifo_status);
        out_vld_d = 1'b1;
        state_d   = ST_RESP;
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        pkt_out_d = build_reply(req_type, chip_id, req_addr,
                                in_range ? bus.regmap_rdata : 8'd0, bus.fifo_status);
        out_vld_d = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (handshake) begin
          if (is_bcast) begin
            pkt_out_d = pkt_q;
            state_d   = ST_FWD;
          end else begin
            pkt_out_d = '0;
            out_vld_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_FWD: begin
        if (handshake) begin
          pkt_out_d = '0;
          out_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pkt_q      <= '0;
      pkt_out_q  <= '0;
      out_vld_q  <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      addr_q     <= 8'd0;
      wdata_q    <= 8'd0;
      perr_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      pkt_out_q  <= pkt_out_d;
      out_vld_q  <= out_vld_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      re_q       <= re_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      perr_q     <= perr_d;
    end
  end

  assign bus.pkt_in_ready  = in_ready_q;
  assign bus.regmap_addr   = addr_q;
  assign bus.regmap_wdata  = wdata_q;
  assign bus.regmap_we     = we_q;
  assign bus.regmap_re     = re_q;
  assign bus.pkt_out       = pkt_out_q;
  assign bus.pkt_out_valid = out_vld_q;
  assign parity_err_cnt    = perr_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_larpix_config_responder.sv
// Directed bench for larpix_config_responder: writes, reads, broadcast,
// forwarding, parity errors, backpressure and mid-operation reset.
module tb_larpix_config_responder;
  import larpix_pkt_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] chip_id = 8'd16;
  logic [7:0] parity_err_cnt;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int re_cnt = 0;

  larpix_config_responder_if #(.WIDTH(64)) bus ();

  larpix_config_responder #(.WIDTH(64), .REGNUM(256), .GLOBAL_ID(8'd255)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .chip_id        (chip_id),
    .bus            (bus),
    .parity_err_cnt (parity_err_cnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Register map stand-in: one-cycle read latency, address 7 holds 0x3C
  always @(posedge clk) begin
    if (bus.regmap_re) bus.regmap_rdata <= (bus.regmap_addr == 8'd7) ? 8'h3C : 8'hEE;
    if (bus.regmap_we) we_cnt <= we_cnt + 1;
    if (bus.regmap_re) re_cnt <= re_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] t, input logic [7:0] chip,
                                     input logic [7:0] addr, input logic [7:0] data,
                                     input logic [3:0] ff, input logic ds);
    logic [63:0] p;
    logic        par;
    p = '0;
    par = 1'b0;
    p[1:0]   = t;
    p[9:2]   = chip;
    p[17:10] = addr;
    p[25:18] = data;
    p[61:58] = ff;
    p[62]    = ds;
    for (int i = 0; i < 63; i++) par = par ^ p[i];
    p[63] = ~par;
    return p;
  endfunction

  task automatic send(input logic [63:0] p);
    int n;
    n = 0;
    while (!bus.pkt_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_seen", 64'(n < 50), 64'd1);
    bus.pkt_in       = p;
    bus.pkt_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.pkt_in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] req, bad;
    int          we0, re0;
    logic        saw_vld;

    bus.pkt_in        = '0;
    bus.pkt_in_valid  = 1'b0;
    bus.fifo_status   = 4'hA;
    bus.pkt_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.pkt_in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.pkt_out_valid), 64'd0);
    chk("rst_pkt_out", bus.pkt_out, 64'd0);
    chk("rst_we_re", 64'({bus.regmap_we, bus.regmap_re}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_perr", 64'(parity_err_cnt), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(bus.pkt_in_ready), 64'd1);

    // Local write
    we0 = we_cnt;
    req = mk(2'd2, 8'd16, 8'd5, 8'hA5, 4'h0, 1'b0);
    send(req);
    @(negedge clk);
    chk("wr_c1_busy", 64'(busy), 64'd1);
    chk("wr_c1_ready", 64'(bus.pkt_in_ready), 64'd0);
    chk("wr_c1_we", 64'(bus.regmap_we), 64'd0);
    @(negedge clk);
    chk("wr_c2_we", 64'(bus.regmap_we), 64'd1);
    chk("wr_c2_addr", 64'(bus.regmap_addr), 64'd5);
    chk("wr_c2_wdata", 64'(bus.regmap_wdata), 64'hA5);
    chk("wr_c2_vld", 64'(bus.pkt_out_valid), 64'd0);
    @(negedge clk);
    chk("wr_c3_we", 64'(bus.regmap_we), 64'd0);
    chk("wr_c3_vld", 64'(bus.pkt_out_valid), 64'd1);
    chk("wr_c3_reply", bus.pkt_out, mk(2'd2, 8'd16, 8'd5, 8'hA5, 4'hA, 1'b1));
    chk("wr_c3_parity", 64'(^bus.pkt_out), 64'd1);
    @(negedge clk);
    chk("wr_c4_vld", 64'(bus.pkt_out_valid), 64'd0);
    chk("wr_c4_busy", 64'(busy), 64'd0);
    chk("wr_we_count", 64'(we_cnt - we0), 64'd1);

    // Local read
    we0 = we_cnt;
    re0 = re_cnt;
    req = mk(2'd3, 8'd16, 8'd7, 8'h00, 4'h0, 1'b0);
    send(req);
    @(negedge clk);
    @(negedge clk);
    chk("rd_c2_re", 64'(bus.regmap_re), 64'd1);
    chk("rd_c2_addr", 64'(bus.regmap_addr), 64'd7);
    @(negedge clk);
    chk("rd_c3_re", 64'(bus.regmap_re), 64'd0);
    chk("rd_c3_vld", 64'(bus.pkt_out_valid), 64'd0);
    @(negedge clk);
    chk("rd_c4_vld", 64'(bus.pkt_out_valid), 64'd1);
    chk("rd_c4_reply", bus.pkt_out, mk(2'd3, 8'd16, 8'd7, 8'h3C, 4'hA, 1'b1));
    @(negedge clk);
    chk("rd_no_we", 64'(we_cnt - we0), 64'd0);
    chk("rd_re_count", 64'(re_cnt - re0), 64'd1);

    // Broadcast write: local write, reply, then forward unchanged
    we0 = we_cnt;
    req = mk(2'd2, 8'd255, 8'd1, 8'h11, 4'h0, 1'b0);
    send(req);
    @(negedge clk);
    @(negedge clk);
    chk("bc_c2_we", 64'(bus.regmap_we), 64'd1);
    chk("bc_c2_addr", 64'(bus.regmap_addr), 64'd1);
    @(negedge clk);
    chk("bc_c3_reply", bus.pkt_out, mk(2'd2, 8'd16, 8'd1, 8'h11, 4'hA, 1'b1));
    @(negedge clk);
    chk("bc_c4_vld", 64'(bus.pkt_out_valid), 64'd1);
    chk("bc_c4_fwd", bus.pkt_out, req);
    @(negedge clk);
    chk("bc_c5_busy", 64'(busy), 64'd0);
    chk("bc_c5_vld", 64'(bus.pkt_out_valid), 64'd0);
    chk("bc_we_count", 64'(we_cnt - we0), 64'd1);

    // Foreign chip: forwarded, no strobes
    we0 = we_cnt;
    re0 = re_cnt;
    req = mk(2'd2, 8'd31, 8'd9, 8'h77, 4'h0, 1'b0);
    send(req);
    @(negedge clk);
    @(negedge clk);
    chk("fw_c2_vld", 64'(bus.pkt_out_valid), 64'd1);
    chk("fw_c2_pkt", bus.pkt_out, req);
    @(negedge clk);
    chk("fw_c3_busy", 64'(busy), 64'd0);
    chk("fw_strobes", 64'((we_cnt - we0) + (re_cnt - re0)), 64'd0);

    // Same packet with bit 20 flipped: parity failure
    bad = req;
    bad[20] = ~bad[20];
    send(bad);
    @(negedge clk);
    @(negedge clk);
    chk("pe_cnt1", 64'(parity_err_cnt), 64'd1);
    chk("pe_vld", 64'(bus.pkt_out_valid), 64'd0);
    chk("pe_busy", 64'(busy), 64'd0);

    // 300 more bad packets: counter must stop at 255
    for (int i = 0; i < 253; i++) send(bad);
    @(negedge clk);
    @(negedge clk);
    chk("pe_cnt254", 64'(parity_err_cnt), 64'd254);
    send(bad);
    @(negedge clk);
    @(negedge clk);
    chk("pe_cnt255", 64'(parity_err_cnt), 64'd255);
    for (int i = 0; i < 46; i++) send(bad);
    @(negedge clk);
    @(negedge clk);
    chk("pe_sat", 64'(parity_err_cnt), 64'd255);

    // Backpressure during RESP
    bus.pkt_out_ready = 1'b0;
    req = mk(2'd2, 8'd16, 8'h20, 8'h5A, 4'h0, 1'b0);
    send(req);
    repeat (3) @(negedge clk);
    chk("bp_vld", 64'(bus.pkt_out_valid), 64'd1);
    chk("bp_reply", bus.pkt_out, mk(2'd2, 8'd16, 8'h20, 8'h5A, 4'hA, 1'b1));
    bus.fifo_status = 4'h5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_pkt", bus.pkt_out, mk(2'd2, 8'd16, 8'h20, 8'h5A, 4'hA, 1'b1));
      chk("bp_hold_vld", 64'(bus.pkt_out_valid), 64'd1);
      chk("bp_hold_ready", 64'(bus.pkt_in_ready), 64'd0);
    end
    bus.pkt_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_vld", 64'(bus.pkt_out_valid), 64'd0);
    chk("bp_release_busy", 64'(busy), 64'd0);
    bus.fifo_status = 4'hA;

    // Reset in the middle of a read
    req = mk(2'd3, 8'd16, 8'd7, 8'h00, 4'h0, 1'b0);
    send(req);
    @(negedge clk);
    @(negedge clk);
    chk("mr_re_before", 64'(bus.regmap_re), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_re", 64'(bus.regmap_re), 64'd0);
    chk("mr_vld", 64'(bus.pkt_out_valid), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_ready", 64'(bus.pkt_in_ready), 64'd0);
    chk("mr_perr", 64'(parity_err_cnt), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      saw_vld = saw_vld | bus.pkt_out_valid;
    end
    chk("mr_no_reply", 64'(saw_vld), 64'd0);
    chk("mr_idle_ready", 64'(bus.pkt_in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/larpix_config_responder.md
Name: larpix_config_responder

Overview:
- Chip-side responder for the 64-bit configuration packet protocol that the master controller drives over the UART link.
- Accepts deserialized packets from the chip's uart_rx and checks parity and chip ID.
- Executes configuration writes and reads against the register map, and builds reply packets for the chip's tx path.
- Sits between uart_rx and the register map / tx FIFO inside the digital core, and forwards packets not addressed to this chip downstream (hydra chaining).

Parameters:
WIDTH, 64, packet width in bits; bit WIDTH-1 is parity.
REGNUM, 256, number of implemented register-map addresses.
GLOBAL_ID, 255, broadcast chip ID.

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
chip_id  input  8  this chip's ID (static after reset)
pkt_in  input  64  received packet
pkt_in_valid  input  1  pkt_in holds a new packet
pkt_in_ready  output  1  block accepts pkt_in this cycle
regmap_addr  output  8  register-map address
regmap_wdata  output  8  register write data
regmap_we  output  1  one-cycle write strobe
regmap_re  output  1  one-cycle read strobe
regmap_rdata  input  8  read data, valid the cycle after regmap_re
fifo_status  input  4  {local_full, local_half, shared_full, shared_half}
pkt_out  output  64  outgoing packet
pkt_out_valid  output  1  pkt_out valid; held until accepted
pkt_out_ready  input  1  tx path accepts pkt_out
parity_err_cnt  output  8  saturating count of parity-failed packets
busy  output  1  high in any state other than IDLE

Behaviour:
- Packet fields:
  - [1:0] type: 0 data, 1 test, 2 cfg write, 3 cfg read
  - [9:2] chip ID
  - [17:10] register address
  - [25:18] register data
  - [58:61] fifo flags
  - [62] downstream marker
  - [63] odd parity over [63:0]: XOR of all 64 bits must be 1.
- Reset: all outputs 0; state IDLE; internal packet register 0; parity_err_cnt 0.
- Reset asserted mid-operation aborts immediately; a pending strobe or reply is discarded, never completed.
- States: IDLE, DECODE, WRITE, READ, CAPTURE, RESP, FWD.
- IDLE:
  - pkt_in_ready=1.
  - On pkt_in_valid, latch pkt_in and go to DECODE (cycle 0 = acceptance edge).
- DECODE (cycle 1): pkt_in_ready=0. Evaluate in order:
  - Parity fail: increment parity_err_cnt (saturate at 255); drop the packet; go to IDLE.
  - chip ID != chip_id and != GLOBAL_ID: go to FWD (unchanged pass-through).
  - Type 0/1 addressed locally: dropped silently; go to IDLE.
  - Type 2: go to WRITE.
  - Type 3: go to READ.
- WRITE (cycle 2):
  - regmap_we=1 for exactly one cycle, with regmap_addr/regmap_wdata from the packet.
  - Address >= REGNUM: no strobe, and reply data field is 0.
  - Go to RESP.
- READ (cycle 2): regmap_re=1 for one cycle; go to CAPTURE.
- CAPTURE (cycle 3):
  - Latch regmap_rdata (0 if address >= REGNUM).
  - Go to RESP.
- Reply packet:
  - Same type as the request.
  - [9:2]=chip_id (own ID, also for broadcast).
  - Address echoed.
  - Data = written data (write) or read data (read).
  - [57:26]=0; [61:58]=fifo_status sampled on the RESP entry cycle; [62]=1.
  - [63] chosen for odd parity.
- RESP:
  - pkt_out_valid=1 first asserted on cycle 3 (write) or cycle 4 (read).
  - pkt_out is stable while valid and !pkt_out_ready.
  - On valid&&ready, go to FWD if the request was broadcast, else IDLE.
- FWD:
  - pkt_out = latched packet unmodified, pkt_out_valid=1.
  - On valid&&ready, go to IDLE.
- Broadcast order: local action, then reply, then forward.
- Back-to-back packets: the next packet is accepted no earlier than the cycle after returning to IDLE; pkt_in_ready is low in all other states.
- pkt_out_ready held low indefinitely stalls the block; nothing is dropped.

Decomposition:
- Package larpix_pkt_pkg:
  - packet-type enum (DATA=0, TEST=1, CFG_WRITE=2, CFG_READ=3)
  - field-position localparams
  - GLOBAL_ID
  - state enum
  - function for odd-parity generate/check
- The master-side testbench shares the same package.
- No sub-module needed; one FSM with a datapath register.

Test Plan:
- Write hit: chip_id=16, type2 addr 5 data 0xA5, valid parity, pkt_out_ready=1.
  - regmap_we one cycle on cycle 2 with addr 5/data 0xA5.
  - Reply type2, chip 16, addr 5, data 0xA5, bit62=1, odd parity on cycle 3.
- Read: regmap returns 0x3C for addr 7, type3 to chip 16.
  - regmap_re on cycle 2; reply type3 data 0x3C on cycle 4; no regmap_we.
- Broadcast: type2 chip 255 addr 1 data 0x11.
  - One write strobe; reply with chip 16; then forwarded packet bit-identical to input.
  - busy low afterwards.
- Foreign/parity:
  - Packet to chip 31 → forwarded unchanged, no strobes.
  - Same packet with bit 20 flipped → dropped, parity_err_cnt 0→1.
  - 300 bad packets → counter saturates at 255.
- Backpressure/reset:
  - Hold pkt_out_ready=0 for 20 cycles during RESP → pkt_out stable, pkt_in_ready=0.
  - Pulse reset_n low → all outputs 0, state IDLE, no reply emitted after reset release.
